pipe_stage_buf: RTL and testbench

- Parametrised pipeline stage buffer carrying one packed stage bundle (ID->EX, EX->MEM or MEM->WB) between adjacent core stages.
- Generalises the plain stage register with three additions:
  - valid/ready handshake on both sides
  - 2-entry skid storage, so back-pressure does not create a combinational ready path and full throughput is kept
  - synchronous flush for branch/exception squash
- Instantiated once per stage boundary; payload width is set per instance.

---
 rtl/pipe_stage_buf.sv | 136 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: a pipeline stage buffer with valid/ready handshakes on both
// sides, two entries of storage and a synchronous flush.
// The main entry drives the output. The skid entry catches a bundle that
// arrives while the head is stalled. in_ready_o comes only from the skid
// flag, so there is no combinational path from out_ready_i to in_ready_o.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall and flush
// performance counters. When the macro is undefined, both counter ports are
// tied to zero.
module pipe_stage_buf #(
    parameter int DATA_W = 336,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              r_main_v;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_main_d;
    logic [DATA_W-1:0] r_skid_d;

    logic              w_main_v_next;
    logic              w_skid_v_next;
    logic [DATA_W-1:0] w_main_d_next;
    logic [DATA_W-1:0] w_skid_d_next;

    logic              w_acc;
    logic              w_pop;
    logic [1:0]        w_occ;

    assign w_acc = in_valid_i & ~r_skid_v;
    assign w_pop = r_main_v & out_ready_i;
    assign w_occ = {r_main_v & r_skid_v, r_main_v ^ r_skid_v};

    assign in_ready_o  = ~r_skid_v;
    assign out_valid_o = r_main_v;
    assign out_data_o  = r_main_d;
    assign occ_o       = w_occ;

    // Next-state selection: flush wins, then the per-occupancy update rules
    always_comb begin
        w_main_v_next = r_main_v;
        w_skid_v_next = r_skid_v;
        w_main_d_next = r_main_d;
        w_skid_d_next = r_skid_d;
        if (flush_i) begin
            // Data registers are left untouched; only the valid flags drop
            w_main_v_next = 1'b0;
            w_skid_v_next = 1'b0;
        end else begin
            case ({r_main_v, r_skid_v})
                2'b00: begin
                    if (w_acc) begin
                        w_main_d_next = in_data_i;
                        w_main_v_next = 1'b1;
                    end
                end
                2'b10: begin
                    if (w_acc && w_pop) begin
                        w_main_d_next = in_data_i;
                    end else if (w_acc) begin
                        w_skid_d_next = in_data_i;
                        w_skid_v_next = 1'b1;
                    end else if (w_pop) begin
                        w_main_v_next = 1'b0;
                    end
                end
                2'b11: begin
                    // Skid only fills behind a valid head, so promote it on pop
                    if (w_pop) begin
                        w_main_d_next = r_skid_d;
                        w_skid_v_next = 1'b0;
                    end
                end
                default: begin
                    // Skid without main cannot occur; hold
                end
            endcase
        end
    end

    // Storage registers, dropped asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            r_main_v <= w_main_v_next;
            r_skid_v <= w_skid_v_next;
            r_main_d <= w_main_d_next;
            r_skid_d <= w_skid_d_next;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W:0]   w_flush_sum;

    assign w_flush_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_occ};

    // Saturating counters for head-stall cycles and squashed entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_v && !out_ready_i && !flush_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush_i) begin
                r_flush_cnt <= w_flush_sum[CNT_W] ? '1 : w_flush_sum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf. The reference model is a bounded queue of
// accepted bundles, with at most two entries, plus saturating event counters.
module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occ_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    int            m_stall;
    int            m_flush;

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occ_o       (occ_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_stall = 0;
        m_flush = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        bit      can_acc;
        bit      do_pop;
        can_acc = in_valid_i && (mq.size() < 2);
        do_pop  = (mq.size() > 0) && out_ready_i;
        if (flush_i) begin
            m_flush = (m_flush + mq.size() > CMAX) ? CMAX : m_flush + mq.size();
            mq.delete();
        end else begin
            if (mq.size() > 0 && !out_ready_i && m_stall < CMAX) m_stall++;
            if (do_pop) void'(mq.pop_front());
            if (can_acc) mq.push_back(in_data_i);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
        n_checks++;
        if (occ_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occ_o); end
        n_checks++;
        if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data_o); end
        n_checks++;
        if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            n_fail++; $display("FAIL reset_counters got stall=%0d flush=%0d exp=0/0", stall_cnt_o, flush_cnt_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(k);
            tick();
            n_checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== DW'(k) || occ_o !== 2'd1 || in_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%0b d=%0h occ=%0d rdy=%0b exp v=1 d=%0h occ=1 rdy=1",
                         k, out_valid_o, out_data_o, occ_o, in_ready_o, k);
            end
            $display("stream beat %0d data=%0h", k, out_data_o);
        end
        in_valid_i = 1'b0;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
            n_fail++; $display("FAIL stream_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid_o, occ_o);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] vc;
        va = 32'hA0A0_0001; vb = 32'hB0B0_0002; vc = 32'hC0C0_0003;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; in_data_i = va; tick();
        in_data_i   = vb; tick();
        n_checks++;
        if (occ_o !== 2'd2 || in_ready_o !== 1'b0 || out_data_o !== va) begin
            n_fail++; $display("FAIL bp_full got occ=%0d rdy=%0b d=%h exp occ=2 rdy=0 d=%h", occ_o, in_ready_o, out_data_o, va);
        end
        in_data_i = vc;
        repeat (2) begin
            tick();
            n_checks++;
            if (occ_o !== 2'd2 || out_valid_o !== 1'b1 || out_data_o !== va) begin
                n_fail++; $display("FAIL bp_hold got occ=%0d v=%0b d=%h exp occ=2 v=1 d=%h", occ_o, out_valid_o, out_data_o, va);
            end
        end
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if (out_data_o !== vb || occ_o !== 2'd1 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got d=%h occ=%0d rdy=%0b exp d=%h occ=1 rdy=1", out_data_o, occ_o, in_ready_o, vb);
        end
        tick();
        in_valid_i = 1'b0;
        n_checks++;
        if (out_data_o !== vc || out_valid_o !== 1'b1 || occ_o !== 2'd1) begin
            n_fail++; $display("FAIL bp_third got d=%h v=%0b occ=%0d exp d=%h v=1 occ=1", out_data_o, out_valid_o, occ_o, vc);
        end
        tick();
        n_checks++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty got occ=%0d v=%0b exp occ=0 v=0", occ_o, out_valid_o);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; in_data_i = 32'h1111; tick();
        in_data_i   = 32'h2222; tick();
        flush_i     = 1'b1;
        in_data_i   = 32'h55;
        tick();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        n_checks++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_state got occ=%0d v=%0b rdy=%0b exp occ=0 v=0 rdy=1", occ_o, out_valid_o, in_ready_o);
        end
`ifdef PIPE_STAGE_PERF_EN
        n_checks++;
        if (flush_cnt_o !== CW'(2)) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=2", flush_cnt_o); end
`else
        n_checks++;
        if (flush_cnt_o !== '0) begin n_fail++; $display("FAIL flush_cnt_off got=%0d exp=0", flush_cnt_o); end
`endif
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_ghost got v=%0b d=%h exp v=0", out_valid_o, out_data_o);
            end
        end
        $display("test_flush done");
    endtask

    task automatic test_stall_sat();
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; in_data_i = 32'h77; tick();
        in_valid_i  = 1'b0;
        repeat (20) tick();
`ifdef PIPE_STAGE_PERF_EN
        n_checks++;
        if (stall_cnt_o !== CW'(CMAX)) begin n_fail++; $display("FAIL stall_sat got=%0d exp=%0d", stall_cnt_o, CMAX); end
`else
        n_checks++;
        if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL stall_off got=%0d exp=0", stall_cnt_o); end
`endif
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h77) begin
            n_fail++; $display("FAIL stall_hold got v=%0b d=%h exp v=1 d=77", out_valid_o, out_data_o);
        end
        $display("test_stall_sat stall_cnt=%0d", stall_cnt_o);
    endtask

    task automatic test_random();
        bit hold;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hold = in_valid_i && (mq.size() == 2);
            if (!hold) begin
                in_valid_i = ($urandom_range(0, 3) != 0);
                in_data_i  = $urandom;
            end
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            tick();
            n_checks++;
            if (out_valid_o !== (mq.size() > 0) || in_ready_o !== (mq.size() < 2) || occ_o !== 2'(mq.size())
                || (mq.size() > 0 && out_data_o !== mq[0])) begin
                n_fail++;
                $display("FAIL random_c%0d got v=%0b rdy=%0b occ=%0d d=%h exp occ=%0d d=%h",
                         c, out_valid_o, in_ready_o, occ_o, out_data_o, mq.size(), (mq.size() > 0) ? mq[0] : '0);
            end
`ifdef PIPE_STAGE_PERF_EN
            n_checks++;
            if (stall_cnt_o !== CW'(m_stall) || flush_cnt_o !== CW'(m_flush)) begin
                n_fail++;
                $display("FAIL random_cnt_c%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                         c, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
            end
`endif
        end
        flush_i = 1'b0; in_valid_i = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1; in_data_i = 32'hD1; tick();
        in_data_i   = 32'hD2; tick();
        n_checks++;
        if (occ_o !== 2'd2) begin n_fail++; $display("FAIL areset_pre got occ=%0d exp=2", occ_o); end
        in_valid_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (occ_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_data_o !== '0) begin
            n_fail++; $display("FAIL areset_async got occ=%0d v=%0b rdy=%0b d=%h exp 0/0/1/0", occ_o, out_valid_o, in_ready_o, out_data_o);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b1; in_data_i = 32'hE5; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hE5) begin
            n_fail++; $display("FAIL areset_after got v=%0b d=%h exp v=1 d=e5", out_valid_o, out_data_o);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
